// File: rtl/uart_rx_fsm_if.sv
// Serial receive bus for uart_rx_fsm: the line input plus the received-frame result signals.
interface uart_rx_fsm_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       parity_err;
    logic       frame_err;

    modport slave (
        input  rx,
        output rx_data, rx_valid, rx_busy, parity_err, frame_err
    );

    modport master (
        output rx,
        input  rx_data, rx_valid, rx_busy, parity_err, frame_err
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver: 1 start, 8 data (LSB first), optional parity, 1 stop; oversampled by CLKS_PER_BIT.
// Define UART_RX_PARITY_EN to include and check the parity bit; otherwise frames are 10 bits.
module uart_rx_fsm #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic         clk,
    input  logic         rst,
    uart_rx_fsm_if.slave bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    generate
        if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0) || (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_cfg
            $error("uart_rx_fsm: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BIT   = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4
    } state_t;

    state_t          r_state, w_state_next;
    logic [1:0]      r_sync;
    logic            w_rx_s;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [2:0]      r_bit, w_bit_next;
    logic [7:0]      r_shift, w_shift_next;
    logic            r_armed, w_armed_next;
    logic            w_done, w_ferr;
    logic [7:0]      r_data;
    logic            r_valid, r_busy, r_perr, r_ferr;
`ifdef UART_RX_PARITY_EN
    logic            r_perr_pend, w_perr_pend_next;

    function automatic logic parity_err_f(input logic [7:0] data, input logic sample);
        return sample ^ (^data) ^ PARITY_ODD[0];
    endfunction
`endif

    assign w_rx_s = r_sync[1];

    // Two-flop synchronizer on the asynchronous line; resets to the idle level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], bus.rx};
    end

    // FSM state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_armed <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_perr_pend <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_armed <= w_armed_next;
`ifdef UART_RX_PARITY_EN
            r_perr_pend <= w_perr_pend_next;
`endif
        end
    end

    // Next-state, bit sampling and frame-complete strobe
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_armed_next = r_armed;
        w_done       = 1'b0;
        w_ferr       = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_pend_next = r_perr_pend;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                w_bit_next = 3'd0;
                if (r_armed && !w_rx_s) begin
                    w_state_next = START_BIT;
                end else if (w_rx_s) begin
                    w_armed_next = 1'b1;
                end else begin
                    w_armed_next = r_armed;
                end
            end
            START_BIT: begin
                if (r_cnt == HALF_CNT) begin
                    w_cnt_next   = '0;
                    w_state_next = w_rx_s ? IDLE : DATA_BIT;
                end else begin
                    w_cnt_next = r_cnt + ONE_CNT;
                end
            end
            DATA_BIT: begin
                if (r_cnt == LAST_CNT) begin
                    w_cnt_next   = '0;
                    w_shift_next = {w_rx_s, r_shift[7:1]};
                    w_bit_next   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = PARITY_BIT;
`else
                        w_state_next = STOP_BIT;
`endif
                    end else begin
                        w_state_next = DATA_BIT;
                    end
                end else begin
                    w_cnt_next = r_cnt + ONE_CNT;
                end
            end
            PARITY_BIT: begin
`ifdef UART_RX_PARITY_EN
                if (r_cnt == LAST_CNT) begin
                    w_cnt_next       = '0;
                    w_perr_pend_next = parity_err_f(r_shift, w_rx_s);
                    w_state_next     = STOP_BIT;
                end else begin
                    w_cnt_next = r_cnt + ONE_CNT;
                end
`else
                w_state_next = IDLE;
`endif
            end
            STOP_BIT: begin
                if (r_cnt == LAST_CNT) begin
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                    w_done       = 1'b1;
                    w_ferr       = ~w_rx_s;
                    // A low stop bit disarms until the line is seen high, so a break gives one frame
                    w_armed_next = w_rx_s;
                end else begin
                    w_cnt_next = r_cnt + ONE_CNT;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Registered outputs: results load and hold on frame completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= w_done;
            r_busy  <= (w_state_next != IDLE);
            if (w_done) begin
                r_data <= r_shift;
                r_ferr <= w_ferr;
`ifdef UART_RX_PARITY_EN
                r_perr <= r_perr_pend;
`else
                r_perr <= 1'b0;
`endif
            end else begin
                r_data <= r_data;
                r_ferr <= r_ferr;
                r_perr <= r_perr;
            end
        end
    end

    assign bus.rx_data    = r_data;
    assign bus.rx_valid   = r_valid;
    assign bus.rx_busy    = r_busy;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: vector table, hand-written corner sequences, random frames.
module tb_uart_rx_fsm;

    localparam int CLKS = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int NBITS  = 11;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int NBITS  = 10;
`endif
    // Ideal valid time: middle of the stop bit, measured from the falling start edge
    localparam int EXP_LAT = CLKS * (NBITS - 1) + CLKS / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    int   n_valid = 0;
    int   n_wide = 0;
    bit   prev_v = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         cyc;
    } obs_t;
    obs_t q[$];

    typedef struct {
        logic [7:0] d;
        logic       pbit;
        logic       stop;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
    } vec_t;

    uart_rx_fsm_if bus();

    uart_rx_fsm #(.CLKS_PER_BIT(CLKS), .PARITY_ODD(0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Capture every rx_valid pulse and flag pulses longer than one cycle
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (bus.rx_valid === 1'b1) begin
                q.push_back('{bus.rx_data, bus.parity_err, bus.frame_err, cyc});
                n_valid++;
                if (prev_v) n_wide++;
            end
            prev_v = (bus.rx_valid === 1'b1);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_tot);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Caller is at a negedge; drives a complete frame, one bit per CLKS cycles
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input bit release_line, output int t_fall);
        logic [10:0] fr;
        fr = 11'h7FF;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[i+1] = d[i];
        if (PAR_EN) begin
            fr[9]  = pbit;
            fr[10] = stop;
        end else begin
            fr[9] = stop;
        end
        t_fall = cyc;
        for (int i = 0; i < NBITS; i++) begin
            bus.rx = fr[i];
            repeat (CLKS) @(negedge clk);
        end
        if (release_line) bus.rx = 1'b1;
    endtask

    task automatic expect_frame(input string nm, input logic [7:0] ed, input logic ep,
                                input logic ef, input int t_fall);
        obs_t r;
        int   waited;
        int   lat;
        waited = 0;
        while (q.size() == 0 && waited < 4 * CLKS) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() == 0) begin
            n_tot++;
            $display("FAIL %s_timeout: no rx_valid within %0d cycles", nm, 4 * CLKS);
        end else begin
            r = q.pop_front();
            chk({nm, "_data"}, 32'(r.d), 32'(ed));
            chk({nm, "_perr"}, 32'(r.pe), 32'(PAR_EN ? ep : 1'b0));
            chk({nm, "_ferr"}, 32'(r.fe), 32'(ef));
            lat = r.cyc - t_fall;
            n_tot++;
            if (lat >= EXP_LAT - 3 && lat <= EXP_LAT + 3) n_pass++;
            else $display("FAIL %s_latency: got %0d cycles expected %0d+/-3", nm, lat, EXP_LAT);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_data"},  32'(bus.rx_data),    32'h0);
        chk({nm, "_valid"}, 32'(bus.rx_valid),   32'h0);
        chk({nm, "_busy"},  32'(bus.rx_busy),    32'h0);
        chk({nm, "_perr"},  32'(bus.parity_err), 32'h0);
        chk({nm, "_ferr"},  32'(bus.frame_err),  32'h0);
    endtask

    initial begin
        vec_t       tbl[8];
        int         tf, tf2, nv, waited;
        logic [7:0] d;
        logic       pbit, stop, ep;
        bit         busy_seen;

        tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[2] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        tbl[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        tbl[5] = '{8'h7E, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1};
        tbl[6] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[7] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};

        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(bus.rx_busy), 32'h0);

        foreach (tbl[i]) begin
            send_frame(tbl[i].d, tbl[i].pbit, tbl[i].stop, 1'b1, tf);
            expect_frame($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ep, tbl[i].ef, tf);
            repeat (3) @(negedge clk);
        end

        // False start: a 4-cycle glitch must not produce a frame
        nv = n_valid;
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        busy_seen = (bus.rx_busy === 1'b1);
        bus.rx = 1'b1;
        chk("false_start_busy_rise", 32'(busy_seen), 32'h1);
        waited = 0;
        while (bus.rx_busy === 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("false_start_busy_drop", 32'(bus.rx_busy), 32'h0);
        repeat (40) @(negedge clk);
        chk("false_start_no_valid", 32'(n_valid - nv), 32'h0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, tf);
        expect_frame("after_glitch", 8'h3C, 1'b0, 1'b0, tf);
        repeat (4) @(negedge clk);

        // Back-to-back frames with no idle time on the line
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, tf);
        send_frame(8'hAA, 1'b0, 1'b1, 1'b1, tf2);
        expect_frame("b2b_first", 8'h55, 1'b0, 1'b0, tf);
        expect_frame("b2b_second", 8'hAA, 1'b0, 1'b0, tf2);
        repeat (4) @(negedge clk);

        // Break: low stop bit then the line held low for 40 bit times
        nv = n_valid;
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, tf);
        repeat (40 * CLKS) @(negedge clk);
        chk("break_one_valid", 32'(n_valid - nv), 32'h1);
        expect_frame("break", 8'h0F, 1'b0, 1'b1, tf);
        bus.rx = 1'b1;
        repeat (8) @(negedge clk);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1, tf);
        expect_frame("after_break", 8'h81, 1'b0, 1'b0, tf);
        repeat (4) @(negedge clk);

        // Reset in the middle of data bit 4 discards the frame
        d = 8'hC3;
        nv = n_valid;
        bus.rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = d[i];
            repeat (CLKS) @(negedge clk);
        end
        bus.rx = d[4];
        repeat (CLKS / 2) @(negedge clk);
        chk("midframe_busy", 32'(bus.rx_busy), 32'h1);
        rst = 1'b1;
        bus.rx = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("midframe_rst");
        rst = 1'b0;
        repeat (12 * CLKS) @(negedge clk);
        chk("midframe_no_valid", 32'(n_valid - nv), 32'h0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1, tf);
        expect_frame("after_rst", 8'hC3, 1'b0, 1'b0, tf);

        // Random frames against a parity/stop reference computed from bit counts
        for (int k = 0; k < 24; k++) begin
            d    = 8'($urandom);
            pbit = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            ep   = ((($countones(d) + int'(pbit)) % 2) != 0);
            send_frame(d, pbit, stop, 1'b1, tf);
            expect_frame($sformatf("rand%0d", k), d, ep, ~stop, tf);
            repeat (stop ? $urandom_range(0, 12) : $urandom_range(3, 12)) @(negedge clk);
        end

        repeat (2 * CLKS) @(negedge clk);
        chk("valid_single_cycle", 32'(n_wide), 32'h0);
        chk("no_extra_valid", 32'(q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, SHALL set clock cycles per serial bit (legal: even, >= 4).
REQ-002 Parameter PARITY_ODD, default 0, SHALL select even (0) or odd (1) parity checking.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port rx  input  1  asynchronous serial line; idle high.
REQ-006 Port rx_data  output  8  last received data byte.
REQ-007 Port rx_valid  output  1  one-cycle pulse: new rx_data, parity_err and frame_err are valid.
REQ-008 Port rx_busy  output  1  high while a frame is in progress.
REQ-009 Port parity_err  output  1  parity mismatch on the last frame.
REQ-010 Port frame_err  output  1  stop bit sampled low on the last frame.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012 States SHALL be IDLE, START_BIT, DATA_BIT, PARITY_BIT and STOP_BIT.
REQ-013 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1).
REQ-014 IDLE -> START_BIT SHALL occur when rx_s = 0 and the block is armed; the bit counter clears.
REQ-015 START_BIT SHALL sample at count = CLKS_PER_BIT/2-1: if 0 -> DATA_BIT with counter cleared; if 1 -> IDLE as a false start, with no output change.
REQ-016 DATA_BIT SHALL sample at count = CLKS_PER_BIT-1 and shift the sample into the shift register MSB (shift right); after the 8th sample it SHALL go to PARITY_BIT.
REQ-017 PARITY_BIT SHALL sample once at count = CLKS_PER_BIT-1; the parity error term = sample XOR (XOR-reduce of data) XOR PARITY_ODD.
REQ-018 STOP_BIT SHALL sample at count = CLKS_PER_BIT-1 and then return to IDLE.
REQ-019 On the clock edge following the stop sample: rx_data <= shift register; parity_err and frame_err update; rx_valid = 1 for exactly one cycle.
REQ-020 rx_data, parity_err and frame_err SHALL hold until the next rx_valid; data SHALL be delivered even when errors are flagged.
REQ-021 After a frame_err, the block SHALL be disarmed until rx_s = 1 is observed, so a held-low line (break) yields one frame only.
REQ-022 rx_busy SHALL be 1 in every state except IDLE.
REQ-023 Back-to-back frames SHALL be received: a start edge in the first IDLE cycle after STOP_BIT is accepted.
REQ-024 The sample counter SHALL be sized ceil(log2(CLKS_PER_BIT)) bits and SHALL never wrap within a bit period.

Reset
REQ-025 While rst = 1: state = IDLE; counters = 0; shift register = 0; rx_data = 0x00; rx_valid = 0; rx_busy = 0; parity_err = 0; frame_err = 0; synchronizer flops = 1; armed = 1.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame with no rx_valid; reception restarts only on a new falling edge.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined: the frame SHALL include the parity bit per REQ-017, and DATA_BIT -> PARITY_BIT -> STOP_BIT.
REQ-028 Without UART_RX_PARITY_EN: PARITY_BIT is unreachable, DATA_BIT -> STOP_BIT directly (10-bit frame), and parity_err is constant 0.

Verification (CLKS_PER_BIT = 16, PARITY_ODD = 0, UART_RX_PARITY_EN defined unless noted)
REQ-029 Frame 0xA5 with parity 0 and stop 1 -> rx_data = 0xA5, single-cycle rx_valid, parity_err = 0, frame_err = 0, rx_valid approx. 168+/-3 cycles after the rx falling edge.
REQ-030 rx low for 4 cycles then high -> no rx_valid, rx_busy drops within 10 cycles, and the next valid frame 0x3C is received correctly.
REQ-031 Frame 0x01 with parity bit 0 -> rx_data = 0x01, parity_err = 1; two immediately back-to-back frames 0x55 then 0xAA -> two rx_valid pulses with correct data.
REQ-032 Frame 0x0F with stop bit 0 and rx then held low for 40 bit times -> exactly one rx_valid with frame_err = 1; after rx returns high, frame 0x81 -> frame_err = 0.
REQ-033 rst pulsed during data bit 4 -> all outputs at reset values, no rx_valid; a subsequent frame 0xC3 is received correctly.
REQ-034 Without UART_RX_PARITY_EN, 10-bit frame 0x3C -> rx_data = 0x3C, parity_err = 0, rx_valid approx. 152+/-3 cycles after the falling edge.
